// File: rtl/rtc_seq_ctrl_if.sv
// rtc_seq_ctrl_if: handshake bundle between the RTC sequencer and its peers.
// slave = controller side, master = engines / user-edit side.
interface rtc_seq_ctrl_if #(
  parameter int NUM_FIELDS = 3,
  parameter int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
);
  logic                  init_done;
  logic                  op_done;
  logic [NUM_FIELDS-1:0] change_req;
  logic                  init_en;
  logic                  read_en;
  logic                  write_en;
  logic [SEL_W-1:0]      write_sel;
  logic [NUM_FIELDS-1:0] change_ack;
  logic [NUM_FIELDS-1:0] pending;
  logic                  busy;
  logic                  timeout_err;

  modport slave (
    input  init_done,
    input  op_done,
    input  change_req,
    output init_en,
    output read_en,
    output write_en,
    output write_sel,
    output change_ack,
    output pending,
    output busy,
    output timeout_err
  );

  modport master (
    output init_done,
    output op_done,
    output change_req,
    input  init_en,
    input  read_en,
    input  write_en,
    input  write_sel,
    input  change_ack,
    input  pending,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/rtc_seq_ctrl.sv
// rtc_seq_ctrl: RTC init / periodic read / queued write sequencer with watchdog.
// Ports: clk, reset (sync, active-high), bus (rtc_seq_ctrl_if.slave).
// Option: RTC_SEQ_RR_EN selects round-robin arbitration (default fixed priority).
module rtc_seq_ctrl #(
  parameter int NUM_FIELDS  = 3,
  parameter int READ_PERIOD = 1000,
  parameter int TIMEOUT     = 4096
) (
  input logic          clk,
  input logic          reset,
  rtc_seq_ctrl_if.slave bus
);
  localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int PER_W = $clog2(READ_PERIOD);
  localparam int WD_W  = $clog2(TIMEOUT);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(READ_PERIOD - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  state_t                state;
  logic [NUM_FIELDS-1:0] pend_q;
  logic [NUM_FIELDS-1:0] ack_q;
  logic [SEL_W-1:0]      sel_q;
  logic [PER_W-1:0]      per_q;
  logic [WD_W-1:0]       wd_q;
  logic                  tmo_q;

  logic [SEL_W-1:0]      grant;
  logic [NUM_FIELDS-1:0] sel_oh;
  logic [NUM_FIELDS-1:0] clr;
  logic                  wd_last;

  assign sel_oh  = NUM_FIELDS'(1) << sel_q;
  assign wd_last = (wd_q == WD_LAST);

  // Completed write clears its bit; a same-cycle request re-sets it.
  always_comb begin
    clr = '0;
    if (state == S_WRITE && bus.op_done)
      clr = sel_oh;
  end

`ifdef RTC_SEQ_RR_EN
  logic [SEL_W-1:0] last_q;
  logic [SEL_W-1:0] idx;

  // Scan downward so the nearest index after last_q wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NUM_FIELDS; k >= 1; k--) begin
      idx = SEL_W'((int'(last_q) + k) % NUM_FIELDS);
      if (pend_q[idx])
        grant = idx;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if (pend_q[i])
        grant = SEL_W'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_INIT;
      pend_q <= '0;
      ack_q  <= '0;
      sel_q  <= '0;
      per_q  <= '0;
      wd_q   <= '0;
      tmo_q  <= 1'b0;
`ifdef RTC_SEQ_RR_EN
      last_q <= SEL_W'(NUM_FIELDS - 1);
`endif
    end else begin
      ack_q  <= '0;
      tmo_q  <= 1'b0;
      pend_q <= (pend_q & ~clr) | bus.change_req;
      unique case (state)
        S_INIT: begin
          if (bus.init_done) begin
            state <= S_IDLE;
            per_q <= '0;
            wd_q  <= '0;
          end else if (wd_last) begin
            tmo_q <= 1'b1;
            wd_q  <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (|pend_q) begin
            state <= S_WRITE;
            sel_q <= grant;
            wd_q  <= '0;
`ifdef RTC_SEQ_RR_EN
            last_q <= grant;
`endif
          end else if (per_q == PER_LAST) begin
            state <= S_READ;
            wd_q  <= '0;
          end else begin
            per_q <= per_q + 1'b1;
          end
        end
        S_READ: begin
          if (bus.op_done) begin
            state <= S_IDLE;
            per_q <= '0;
            wd_q  <= '0;
          end else if (wd_last) begin
            state <= S_INIT;
            tmo_q <= 1'b1;
            wd_q  <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.op_done) begin
            state <= S_READ;
            ack_q <= sel_oh;
            wd_q  <= '0;
          end else if (wd_last) begin
            state <= S_INIT;
            tmo_q <= 1'b1;
            wd_q  <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.init_en     = (state == S_INIT);
  assign bus.read_en     = (state == S_READ);
  assign bus.write_en    = (state == S_WRITE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.write_sel   = sel_q;
  assign bus.change_ack  = ack_q;
  assign bus.pending     = pend_q;
  assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_rtc_seq_ctrl.sv
// tb_rtc_seq_ctrl: directed bench for rtc_seq_ctrl.
// NUM_FIELDS=3, READ_PERIOD=8, TIMEOUT=16.
module tb_rtc_seq_ctrl;
  localparam int NF = 3;
  localparam int RP = 8;
  localparam int TO = 16;

`ifdef RTC_SEQ_RR_EN
  localparam logic [1:0] G1 = 2'd2;
  localparam logic [1:0] G2 = 2'd0;
`else
  localparam logic [1:0] G1 = 2'd0;
  localparam logic [1:0] G2 = 2'd2;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] oh1, oh2;

  always #5 clk = ~clk;

  rtc_seq_ctrl_if #(.NUM_FIELDS(NF)) bus ();

  rtc_seq_ctrl #(
    .NUM_FIELDS (NF),
    .READ_PERIOD(RP),
    .TIMEOUT    (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  initial begin
    oh1 = 3'b001 << G1;
    oh2 = 3'b001 << G2;
    reset = 1'b1;
    bus.init_done  = 1'b0;
    bus.op_done    = 1'b0;
    bus.change_req = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_init_en", 32'(bus.init_en), 1);
    chk("rst_busy", 32'(bus.busy), 1);
    chk("rst_read_en", 32'(bus.read_en), 0);
    chk("rst_write_en", 32'(bus.write_en), 0);
    chk("rst_pending", 32'(bus.pending), 0);
    chk("rst_ack", 32'(bus.change_ack), 0);
    chk("rst_tmo", 32'(bus.timeout_err), 0);
    chk("rst_sel", 32'(bus.write_sel), 0);

    for (int i = 0; i < 11; i++) begin
      chk("init_en_hold", 32'(bus.init_en), 1);
      bus.init_done = (i == 10);
      tick();
    end
    bus.init_done = 1'b0;

    for (int i = 0; i < RP; i++) begin
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_read_en", 32'(bus.read_en), 0);
      tick();
    end
    chk("auto_read_en", 32'(bus.read_en), 1);
    chk("auto_read_busy", 32'(bus.busy), 1);
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("read_done_idle", 32'(bus.busy), 0);

    bus.change_req = 3'b010;
    tick();
    bus.change_req = '0;
    chk("t2_pend", 32'(bus.pending), 3'b010);
    chk("t2_no_write_yet", 32'(bus.write_en), 0);
    tick();
    chk("t2_write_en", 32'(bus.write_en), 1);
    chk("t2_sel", 32'(bus.write_sel), 1);
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("t2_ack", 32'(bus.change_ack), 3'b010);
    chk("t2_readback", 32'(bus.read_en), 1);
    chk("t2_pend_clr", 32'(bus.pending), 0);
    tick();
    chk("t2_ack_pulse", 32'(bus.change_ack), 0);
    chk("t2_read_hold", 32'(bus.read_en), 1);
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("t2_idle", 32'(bus.busy), 0);

    bus.change_req = 3'b101;
    tick();
    bus.change_req = '0;
    chk("t3_pend", 32'(bus.pending), 3'b101);
    tick();
    chk("t3_sel1", 32'(bus.write_sel), 32'(G1));
    bus.op_done = 1'b1;
    tick();
    chk("t3_ack1", 32'(bus.change_ack), 32'(oh1));
    chk("t3_pend1", 32'(bus.pending), 32'(3'b101 & ~oh1));
    tick();
    bus.op_done = 1'b0;
    chk("t3_idle", 32'(bus.busy), 0);
    tick();
    chk("t3_write2", 32'(bus.write_en), 1);
    chk("t3_sel2", 32'(bus.write_sel), 32'(G2));
    bus.op_done = 1'b1;
    tick();
    chk("t3_ack2", 32'(bus.change_ack), 32'(oh2));
    tick();
    bus.op_done = 1'b0;
    chk("t3_pend_done", 32'(bus.pending), 0);
    chk("t3_idle2", 32'(bus.busy), 0);

    bus.change_req = 3'b001;
    tick();
    bus.change_req = '0;
    tick();
    chk("t4_sel", 32'(bus.write_sel), 0);
    bus.op_done    = 1'b1;
    bus.change_req = 3'b001;
    tick();
    bus.op_done    = 1'b0;
    bus.change_req = '0;
    chk("t4_ack", 32'(bus.change_ack), 3'b001);
    chk("t4_pend_kept", 32'(bus.pending), 3'b001);
    tick();
    chk("t4_read", 32'(bus.read_en), 1);
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("t4_idle", 32'(bus.busy), 0);
    tick();
    chk("t4_rewrite", 32'(bus.write_en), 1);
    chk("t4_rewrite_sel", 32'(bus.write_sel), 0);
    bus.op_done = 1'b1;
    tick();
    tick();
    bus.op_done = 1'b0;
    chk("t4_pend_done", 32'(bus.pending), 0);

    for (int i = 0; i < 3 * RP && !bus.read_en; i++)
      tick();
    chk("t5_read_reached", 32'(bus.read_en), 1);
    for (int i = 0; i < TO; i++) begin
      chk("t5_read_hold", 32'(bus.read_en), 1);
      chk("t5_no_tmo", 32'(bus.timeout_err), 0);
      bus.change_req = (i == 0) ? 3'b100 : 3'b000;
      tick();
    end
    chk("t5_tmo", 32'(bus.timeout_err), 1);
    chk("t5_init", 32'(bus.init_en), 1);
    chk("t5_pend", 32'(bus.pending), 3'b100);
    bus.init_done = 1'b1;
    tick();
    bus.init_done = 1'b0;
    chk("t5_tmo_pulse", 32'(bus.timeout_err), 0);
    chk("t5_idle", 32'(bus.busy), 0);
    tick();
    chk("t5_retry", 32'(bus.write_en), 1);
    chk("t5_retry_sel", 32'(bus.write_sel), 2);

    bus.change_req = 3'b011;
    tick();
    bus.change_req = '0;
    chk("t6_pend", 32'(bus.pending), 3'b111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_init", 32'(bus.init_en), 1);
    chk("t6_pend_clr", 32'(bus.pending), 0);
    chk("t6_no_ack", 32'(bus.change_ack), 0);
    chk("t6_no_write", 32'(bus.write_en), 0);
    tick();
    chk("t6_no_ack2", 32'(bus.change_ack), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
